// File: rtl/tdm_demux_1_4_if.sv
// tdm_demux_1_4_if
// Purpose : groups the sample-stream inputs and the demultiplexed frame
//           outputs of tdm_demux_1_4 into one bundle.
// Ports   : master modport - drives Enable_In, Data_In, Valid_In and
//           Frame_Sync_In, and observes all outputs (testbench/upstream side)
//           slave modport  - the demux itself, which consumes the inputs and
//           drives Data_0_Out..Data_3_Out, Frame_Valid_Out, Channel_Out,
//           Locked_Out and Sync_Error_Out
interface tdm_demux_1_4_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Enable_In;
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Valid_In;
    logic                  Frame_Sync_In;
    logic [DATA_WIDTH-1:0] Data_0_Out;
    logic [DATA_WIDTH-1:0] Data_1_Out;
    logic [DATA_WIDTH-1:0] Data_2_Out;
    logic [DATA_WIDTH-1:0] Data_3_Out;
    logic                  Frame_Valid_Out;
    logic [1:0]            Channel_Out;
    logic                  Locked_Out;
    logic                  Sync_Error_Out;

    modport master (
        output Enable_In, Data_In, Valid_In, Frame_Sync_In,
        input  Data_0_Out, Data_1_Out, Data_2_Out, Data_3_Out,
        input  Frame_Valid_Out, Channel_Out, Locked_Out, Sync_Error_Out
    );

    modport slave (
        input  Enable_In, Data_In, Valid_In, Frame_Sync_In,
        output Data_0_Out, Data_1_Out, Data_2_Out, Data_3_Out,
        output Frame_Valid_Out, Channel_Out, Locked_Out, Sync_Error_Out
    );
endinterface

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4
// Purpose : splits a serial time-division stream of four channels into four
//           registered per-channel outputs. A frame starts at a sample marked
//           by Frame_Sync_In; the four outputs load together when the
//           channel 3 sample arrives, so they never show a partial frame.
// Ports   : Clock_In  - single clock, rising edge
//           Reset_In  - synchronous, active-high reset
//           bus       - tdm_demux_1_4_if slave modport carrying the enable,
//                       sample stream, sync marker and all frame outputs
module tdm_demux_1_4 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           Clock_In,
    input  logic           Reset_In,
    tdm_demux_1_4_if.slave bus
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] stage_q [0:2];
    logic [DATA_WIDTH-1:0] stage_d [0:2];
    logic [DATA_WIDTH-1:0] out_q   [0:3];
    logic [DATA_WIDTH-1:0] out_d   [0:3];
    logic                  frame_valid_q, frame_valid_d;
    logic                  sync_error_q, sync_error_d;
    logic                  accept;

    assign accept = bus.Enable_In && bus.Valid_In;

    // State register. Reset wins over everything else, including enable.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q       <= HUNT;
            cnt_q         <= 2'd0;
            frame_valid_q <= 1'b0;
            sync_error_q  <= 1'b0;
            for (int i = 0; i < 3; i++) stage_q[i] <= '0;
            for (int i = 0; i < 4; i++) out_q[i]   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_valid_q <= frame_valid_d;
            sync_error_q  <= sync_error_d;
            stage_q       <= stage_d;
            out_q         <= out_d;
        end
    end

    // Next-state logic. Non-accepted cycles keep everything and let the
    // one-cycle pulses fall back to 0. A sync that arrives mid-frame restarts
    // the frame at channel 0; the old partial frame is simply overwritten
    // and the outputs keep the last complete frame.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage_d       = stage_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_error_d  = 1'b0;

        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (bus.Frame_Sync_In) begin
                        stage_d[0] = bus.Data_In;
                        cnt_d      = 2'd1;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (bus.Frame_Sync_In && (cnt_q != 2'd0)) begin
                        stage_d[0]   = bus.Data_In;
                        cnt_d        = 2'd1;
                        sync_error_d = 1'b1;
                    end else begin
                        case (cnt_q)
                            2'd0: stage_d[0] = bus.Data_In;
                            2'd1: stage_d[1] = bus.Data_In;
                            2'd2: stage_d[2] = bus.Data_In;
                            default: begin
                                out_d[0]      = stage_q[0];
                                out_d[1]      = stage_q[1];
                                out_d[2]      = stage_q[2];
                                out_d[3]      = bus.Data_In;
                                frame_valid_d = 1'b1;
                            end
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.Data_0_Out      = out_q[0];
    assign bus.Data_1_Out      = out_q[1];
    assign bus.Data_2_Out      = out_q[2];
    assign bus.Data_3_Out      = out_q[3];
    assign bus.Frame_Valid_Out = frame_valid_q;
    assign bus.Sync_Error_Out  = sync_error_q;
    assign bus.Channel_Out     = cnt_q;
    assign bus.Locked_Out      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb_tdm_demux_1_4
// Purpose : self-checking bench for tdm_demux_1_4. A small reference model
//           of the frame alignment predicts every cycle's outputs; completed
//           frames are pushed to a scoreboard queue when their last sample is
//           driven and popped when Frame_Valid_Out is seen.
// Ports   : none (top-level bench)
module tb_tdm_demux_1_4;

    localparam int DW = 8;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   frames_seen;
    int   fv_pulses;

    logic [31:0] exp_q [$];

    // Reference model state
    logic       m_locked;
    logic [1:0] m_cnt;
    logic [7:0] m_stage [0:2];
    logic [7:0] m_out   [0:3];

    tdm_demux_1_4_if #(.DATA_WIDTH(DW)) bus ();

    tdm_demux_1_4 #(.DATA_WIDTH(DW)) dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%h required=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle, advances the model, then checks all outputs #1 after
    // the edge.
    task automatic applyStimulus(input logic r, input logic en, input logic vld,
                                 input logic sync, input logic [7:0] d);
        logic exp_fv;
        logic exp_se;
        exp_fv = 1'b0;
        exp_se = 1'b0;
        rst               = r;
        bus.Enable_In     = en;
        bus.Valid_In      = vld;
        bus.Frame_Sync_In = sync;
        bus.Data_In       = d;

        if (r) begin
            m_locked = 1'b0;
            m_cnt    = 2'd0;
            for (int i = 0; i < 3; i++) m_stage[i] = 8'h00;
            for (int i = 0; i < 4; i++) m_out[i]   = 8'h00;
        end else if (en && vld) begin
            if (!m_locked) begin
                if (sync) begin
                    m_stage[0] = d;
                    m_cnt      = 2'd1;
                    m_locked   = 1'b1;
                end
            end else if (sync && m_cnt != 2'd0) begin
                m_stage[0] = d;
                m_cnt      = 2'd1;
                exp_se     = 1'b1;
            end else if (m_cnt == 2'd3) begin
                m_out[0] = m_stage[0];
                m_out[1] = m_stage[1];
                m_out[2] = m_stage[2];
                m_out[3] = d;
                exp_fv   = 1'b1;
                m_cnt    = 2'd0;
                exp_q.push_back({m_stage[0], m_stage[1], m_stage[2], d});
            end else begin
                m_stage[m_cnt] = d;
                m_cnt          = m_cnt + 2'd1;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("channel", {30'd0, bus.Channel_Out}, {30'd0, m_cnt});
        checkOutput("locked", {31'd0, bus.Locked_Out}, {31'd0, m_locked});
        checkOutput("frame_valid", {31'd0, bus.Frame_Valid_Out}, {31'd0, exp_fv});
        checkOutput("sync_error", {31'd0, bus.Sync_Error_Out}, {31'd0, exp_se});
        checkOutput("data_out",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    {m_out[0], m_out[1], m_out[2], m_out[3]});
        if (bus.Frame_Valid_Out) fv_pulses++;
    endtask

    // Scoreboard side: every Frame_Valid_Out pulse must match the oldest
    // predicted frame.
    always @(negedge clk) begin
        if (!rst && bus.Frame_Valid_Out === 1'b1) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_frame", 32'd1, 32'd0);
            end else begin
                checkOutput("scoreboard_frame",
                            {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                            exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] t6 [0:11];
        tests_run    = 0;
        tests_failed = 0;
        frames_seen  = 0;
        fv_pulses    = 0;
        rst               = 1'b1;
        bus.Enable_In     = 1'b0;
        bus.Valid_In      = 1'b0;
        bus.Frame_Sync_In = 1'b0;
        bus.Data_In       = 8'h00;

        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(1, 1, 1, 1, 8'h5A);
        checkOutput("reset_locked", {31'd0, bus.Locked_Out}, 32'd0);
        checkOutput("reset_data0", {24'd0, bus.Data_0_Out}, 32'd0);

        // HUNT drops unsynced samples
        applyStimulus(0, 1, 1, 0, 8'hAA);
        applyStimulus(0, 1, 1, 0, 8'hBB);
        checkOutput("hunt_locked", {31'd0, bus.Locked_Out}, 32'd0);
        checkOutput("hunt_channel", {30'd0, bus.Channel_Out}, 32'd0);
        applyStimulus(0, 1, 0, 1, 8'hCC);
        checkOutput("sync_without_valid", {31'd0, bus.Locked_Out}, 32'd0);

        // Basic frame
        applyStimulus(0, 1, 1, 1, 8'h11);
        checkOutput("t1_locked", {31'd0, bus.Locked_Out}, 32'd1);
        applyStimulus(0, 1, 1, 0, 8'h22);
        applyStimulus(0, 1, 1, 0, 8'h33);
        applyStimulus(0, 1, 1, 0, 8'h44);
        checkOutput("t1_frame",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    32'h11223344);
        checkOutput("t1_fv", {31'd0, bus.Frame_Valid_Out}, 32'd1);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t1_fv_drop", {31'd0, bus.Frame_Valid_Out}, 32'd0);

        // Mid-frame resync
        applyStimulus(0, 1, 1, 1, 8'h01);
        applyStimulus(0, 1, 1, 0, 8'h02);
        applyStimulus(0, 1, 1, 1, 8'h05);
        checkOutput("t3_sync_err", {31'd0, bus.Sync_Error_Out}, 32'd1);
        checkOutput("t3_channel", {30'd0, bus.Channel_Out}, 32'd1);
        checkOutput("t3_hold",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    32'h11223344);
        applyStimulus(0, 1, 1, 0, 8'h06);
        applyStimulus(0, 1, 1, 0, 8'h07);
        applyStimulus(0, 1, 1, 0, 8'h08);
        checkOutput("t3_frame",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    32'h05060708);

        // Enable low mid-frame
        applyStimulus(0, 1, 1, 1, 8'h21);
        applyStimulus(0, 1, 1, 0, 8'h22);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 8'hFF);
        applyStimulus(0, 1, 1, 0, 8'h23);
        applyStimulus(0, 1, 1, 0, 8'h24);
        checkOutput("t4_frame",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    32'h21222324);

        // Reset mid-frame
        applyStimulus(0, 1, 1, 1, 8'h31);
        applyStimulus(0, 1, 1, 0, 8'h32);
        applyStimulus(1, 1, 1, 0, 8'h33);
        checkOutput("t5_reset_data",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    32'h00000000);
        checkOutput("t5_reset_locked", {31'd0, bus.Locked_Out}, 32'd0);
        applyStimulus(0, 1, 1, 0, 8'h34);
        applyStimulus(0, 1, 1, 1, 8'h41);
        applyStimulus(0, 1, 1, 0, 8'h42);
        applyStimulus(0, 1, 1, 0, 8'h43);
        applyStimulus(0, 1, 1, 0, 8'h44);
        checkOutput("t5_frame",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    32'h41424344);

        // Back-to-back frames, Valid_In high for 12 cycles
        fv_pulses = 0;
        for (int i = 0; i < 12; i++) t6[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, (i == 0), t6[i]);
        checkOutput("t6_pulses", fv_pulses, 32'd3);
        checkOutput("t6_last_frame",
                    {bus.Data_0_Out, bus.Data_1_Out, bus.Data_2_Out, bus.Data_3_Out},
                    {t6[8], t6[9], t6[10], t6[11]});
        applyStimulus(0, 1, 0, 0, 8'h00);

        checkOutput("frames_seen", frames_seen, 32'd7);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
